// File: rtl/fetch_sched.sv
// Fetch-stage sequencer: boot hold-off, branch redirects, load-use stalls and
// instruction-memory wait states for the pipelined MIPS front end.
module fetch_sched #(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             PCSrc,
    output logic [31:0]      PCBranch,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_RUN      = 2'd1,
        S_WAIT_MEM = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       boot_cnt_q, boot_cnt_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use;

    // ex_rt==0 is $zero: a load into it can never create a real dependency
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= 8'd0;
            target_q   <= 32'd0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            target_q   <= target_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        target_d    = target_q;
        stall_d     = stall_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        PCSrc       = 1'b0;
        PCBranch    = 32'd0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        case (state_q)
            S_BOOT: begin
                pc_en       = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                boot_cnt_d  = boot_cnt_q + 8'd1;
                if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
            end
            S_RUN, S_WAIT_MEM: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    if (imem_ready) begin
                        PCSrc    = 1'b1;
                        PCBranch = branch_target;
                        state_d  = S_RUN;
                    end else begin
                        pc_en    = 1'b0;
                        target_d = branch_target;
                        state_d  = S_REDIRECT;
                    end
                end else if (state_q == S_RUN && load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    if (stall_q != '1) stall_d = stall_q + 1'b1;
                end else if (!imem_ready) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = S_WAIT_MEM;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_REDIRECT: begin
                // a younger branch_taken is ignored: the latched redirect owns the pipe
                ifid_flush = 1'b1;
                if (imem_ready) begin
                    PCSrc    = 1'b1;
                    PCBranch = target_q;
                    state_d  = S_RUN;
                end else begin
                    pc_en = 1'b0;
                end
            end
            default: state_d = S_BOOT;
        endcase

        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            PCSrc       = 1'b0;
            PCBranch    = 32'd0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fetch_sched.sv
// Randomized self-checking bench for fetch_sched against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_fetch_sched;

    localparam int BOOT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rt = 5'd0, id_rs = 5'd0, id_rt = 5'd0;
    logic        id_uses_rt = 1'b0;
    logic        imem_ready = 1'b1;

    logic        pc_en, PCSrc, ifid_en, ifid_flush, idex_flush, exmem_flush;
    logic [31:0] PCBranch;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    logic        s_pc_en, s_PCSrc, s_ifid_en, s_ifid_flush, s_idex_flush, s_exmem_flush;
    logic [31:0] s_PCBranch;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // behavioural model state
    int          boot_seen;
    bit          waiting, pending;
    logic [31:0] pend_tgt;
    int          stalls_big, stalls_small;

    always #5 clk = ~clk;

    fetch_sched #(.BOOT_CYCLES(BOOT), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .imem_ready(imem_ready),
        .pc_en(pc_en), .PCSrc(PCSrc), .PCBranch(PCBranch), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .state(state), .stall_cnt(stall_cnt)
    );

    fetch_sched #(.BOOT_CYCLES(BOOT), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .imem_ready(imem_ready),
        .pc_en(s_pc_en), .PCSrc(s_PCSrc), .PCBranch(s_PCBranch), .ifid_en(s_ifid_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
        .state(s_state), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        boot_seen    = 0;
        waiting      = 1'b0;
        pending      = 1'b0;
        pend_tgt     = 32'd0;
        stalls_big   = 0;
        stalls_small = 0;
    endtask

    task automatic check_reset_outputs(input string who);
        chk({who, ".pc_en"},       {31'd0, pc_en},       32'd0);
        chk({who, ".PCSrc"},       {31'd0, PCSrc},       32'd0);
        chk({who, ".PCBranch"},    PCBranch,             32'd0);
        chk({who, ".ifid_en"},     {31'd0, ifid_en},     32'd0);
        chk({who, ".flushes"},     {29'd0, ifid_flush, idex_flush, exmem_flush}, 32'd7);
        chk({who, ".state"},       {30'd0, state},       32'd0);
        chk({who, ".stall_cnt"},   {16'd0, stall_cnt},   32'd0);
        chk({who, ".small_stall"}, {30'd0, s_stall_cnt}, 32'd0);
    endtask

    // Called at posedge+1; drives, checks at posedge+6, advances model, returns at next posedge+1.
    task automatic do_cycle(input bit br, input logic [31:0] tgt, input bit mr,
                            input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                            input bit urt, input bit rdy);
        bit e_pc, e_src, e_ifen, e_iff, e_idf, e_exf, dep;
        logic [31:0] e_pcb;
        int e_state;

        branch_taken = br; branch_target = tgt; ex_memread = mr;
        ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt; imem_ready = rdy;

        e_pc = 1; e_src = 0; e_ifen = 1; e_iff = 0; e_idf = 0; e_exf = 0; e_pcb = 32'd0;
        e_state = (boot_seen < BOOT) ? 0 : pending ? 3 : waiting ? 2 : 1;
        dep = mr && (ert != 0) && ((rs == ert) || (urt && (rt == ert)));

        if (boot_seen < BOOT) begin
            e_pc = 0; e_iff = 1; e_idf = 1; e_exf = 1;
            boot_seen++;
        end else if (pending) begin
            e_iff = 1;
            if (rdy) begin
                e_src = 1; e_pcb = pend_tgt; pending = 0;
            end else begin
                e_pc = 0;
            end
        end else if (br) begin
            e_iff = 1; e_idf = 1; e_exf = 1; waiting = 0;
            if (rdy) begin
                e_src = 1; e_pcb = tgt;
            end else begin
                e_pc = 0; pending = 1; pend_tgt = tgt;
            end
        end else if (!waiting && dep) begin
            e_pc = 0; e_ifen = 0; e_idf = 1;
            if (stalls_big < 65535) stalls_big++;
            if (stalls_small < 3) stalls_small++;
        end else if (!rdy) begin
            e_pc = 0; e_iff = 1; waiting = 1;
        end else begin
            waiting = 0;
        end

        #5;
        chk("pc_en",    {31'd0, pc_en},       {31'd0, e_pc});
        chk("PCSrc",    {31'd0, PCSrc},       {31'd0, e_src});
        chk("PCBranch", PCBranch,             e_pcb);
        chk("ifid_en",  {31'd0, ifid_en},     {31'd0, e_ifen});
        chk("flushes",  {29'd0, ifid_flush, idex_flush, exmem_flush}, {29'd0, e_iff, e_idf, e_exf});
        chk("state",    {30'd0, state},       32'(e_state));
        chk("small_state", {30'd0, s_state},  32'(e_state));
        @(posedge clk);
        #1;
        cyc++;
        chk("stall_cnt",   {16'd0, stall_cnt},   32'(stalls_big));
        chk("small_stall", {30'd0, s_stall_cnt}, 32'(stalls_small));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) do_cycle(0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 0, rdy);
    endtask

    task automatic reset_pulse();
        #1 rst = 1'b0;
        #0.5;
        check_reset_outputs("rst_pulse");
        #0.5 rst = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #3;
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst = 1'b1;

        // boot then directed scenarios
        idle(BOOT + 2, 1);
        do_cycle(0, 32'd0, 1, 5'd8, 5'd8, 5'd3, 0, 1);
        do_cycle(0, 32'd0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        do_cycle(1, 32'h40, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        do_cycle(1, 32'h80, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        do_cycle(1, 32'h100, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        do_cycle(0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        do_cycle(0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        do_cycle(1, 32'h1234, 1, 5'd5, 5'd2, 5'd5, 1, 1);
        do_cycle(0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        do_cycle(1, 32'h200, 0, 5'd0, 5'd0, 5'd0, 0, 1);

        // reset while a redirect is pending, then saturate the narrow counter
        do_cycle(1, 32'hDEAD0000, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        reset_pulse();
        idle(BOOT + 1, 1);
        for (int i = 0; i < 5; i++) do_cycle(0, 32'd0, 1, 5'd7, 5'd1, 5'd7, 1, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            do_cycle(($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 2) == 0),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 9) < 7));
            if ($urandom_range(0, 399) == 0) reset_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
